ulpi_tx_sequencer: RTL and testbench

//  Link-side ULPI transmit sequencer feeding Physical_Interface: takes USB packet bytes from the

---
 rtl/ulpi_tx_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_ulpi_tx_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_tx_sequencer
// Description : Link-side ULPI transmit sequencer. Takes packet bytes over
//               valid/ready, emits TX CMD, data and STP on the 8-bit ULPI bus.
//               It follows PHY dir/nxt, inserts turnaround cycles, retries a
//               TX CMD lost to the PHY, and aborts on bus loss or underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module ulpi_tx_sequencer #(
    parameter logic [1:0]  TXCMD_CODE = 2'b01,
    parameter int unsigned IDLE_GAP   = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] pkt_data_i,
    input  logic       pkt_valid_i,
    input  logic       pkt_last_i,
    output logic       pkt_ready_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    output logic       tx_oe_o,
    output logic [7:0] tx_data_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_abort_o
);

    localparam int unsigned          c_GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [c_GAP_W-1:0]   c_GAP_LOAD = c_GAP_W'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TURN  = 3'd1,
        S_TXCMD = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_dir_q;     // dir seen last cycle, for edge detection
    logic                 r_tx_oe;
    logic [7:0]           r_tx_data;
    logic                 r_stp;
    logic                 r_done;
    logic                 r_abort;
    logic [c_GAP_W-1:0]   r_gap;       // idle cycles still owed after a STOP
    logic                 r_pid_pend;  // TX CMD was lost to the PHY, resend stored PID
    logic [3:0]           r_pid;
    logic                 r_last;      // byte currently on the bus is the packet's last
    logic                 r_underrun;  // STOP was an underrun abort, drain afterwards
    logic                 r_dir_chg;   // dir toggled while draining, turnaround needed

    logic                 w_dir_edge;
    logic                 w_can_start;
    logic                 w_ready;

    assign w_dir_edge  = ulpi_dir_i ^ r_dir_q;
    assign w_can_start = !ulpi_dir_i && !w_dir_edge && (r_gap == '0);

    // Byte-consume strobe: only ever asserted together with pkt_valid_i
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:          w_ready = w_can_start && !r_pid_pend && pkt_valid_i;
            S_TXCMD, S_DATA: w_ready = !ulpi_dir_i && ulpi_nxt_i && !r_last && pkt_valid_i;
            S_DRAIN:         w_ready = pkt_valid_i;
            default:         w_ready = 1'b0;
        endcase
    end

    assign pkt_ready_o = w_ready;
    assign ulpi_stp_o  = r_stp;
    assign tx_oe_o     = r_tx_oe;
    assign tx_data_o   = r_tx_data;
    assign busy_o      = (r_state != S_IDLE);
    assign tx_done_o   = r_done;
    assign tx_abort_o  = r_abort;

    // Sequencer FSM with registered bus-side outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_dir_q    <= 1'b0;
            r_tx_oe    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_stp      <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_gap      <= '0;
            r_pid_pend <= 1'b0;
            r_pid      <= 4'h0;
            r_last     <= 1'b0;
            r_underrun <= 1'b0;
            r_dir_chg  <= 1'b0;
        end else begin
            r_dir_q <= ulpi_dir_i;
            r_stp   <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_dir_edge) begin
                        r_state <= S_TURN;
                    end else if (w_can_start && (r_pid_pend || pkt_valid_i)) begin
                        r_state <= S_TXCMD;
                        r_tx_oe <= 1'b1;
                        if (r_pid_pend) begin
                            r_tx_data <= {TXCMD_CODE, 2'b00, r_pid};
                        end else begin
                            r_pid     <= pkt_data_i[3:0];
                            r_last    <= pkt_last_i;
                            r_tx_data <= {TXCMD_CODE, 2'b00, pkt_data_i[3:0]};
                        end
                    end
                end

                S_TURN: begin
                    // Another dir toggle restarts the turnaround cycle
                    if (!w_dir_edge) begin
                        r_state <= S_IDLE;
                    end
                end

                S_TXCMD: begin
                    if (ulpi_dir_i) begin
                        // PHY grabbed the bus before accepting the TX CMD: retry later
                        r_pid_pend <= 1'b1;
                        r_tx_oe    <= 1'b0;
                        r_state    <= S_TURN;
                    end else if (ulpi_nxt_i) begin
                        r_pid_pend <= 1'b0;
                        if (r_last) begin
                            r_tx_data <= 8'h00;
                            r_stp     <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_STOP;
                        end else if (pkt_valid_i) begin
                            r_tx_data <= pkt_data_i;
                            r_last    <= pkt_last_i;
                            r_state   <= S_DATA;
                        end else begin
                            r_tx_data  <= 8'hFF;
                            r_stp      <= 1'b1;
                            r_abort    <= 1'b1;
                            r_underrun <= 1'b1;
                            r_state    <= S_STOP;
                        end
                    end
                end

                S_DATA: begin
                    if (ulpi_dir_i) begin
                        // Bus lost mid-packet: no STP, discard whatever is left
                        r_tx_oe <= 1'b0;
                        r_abort <= 1'b1;
                        if (r_last) begin
                            r_state <= S_TURN;
                        end else begin
                            r_dir_chg <= 1'b1;
                            r_state   <= S_DRAIN;
                        end
                    end else if (ulpi_nxt_i) begin
                        if (r_last) begin
                            r_tx_data <= 8'h00;
                            r_stp     <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_STOP;
                        end else if (pkt_valid_i) begin
                            r_tx_data <= pkt_data_i;
                            r_last    <= pkt_last_i;
                        end else begin
                            r_tx_data  <= 8'hFF;
                            r_stp      <= 1'b1;
                            r_abort    <= 1'b1;
                            r_underrun <= 1'b1;
                            r_state    <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    r_tx_oe    <= 1'b0;
                    r_tx_data  <= 8'h00;
                    r_gap      <= c_GAP_LOAD;
                    r_underrun <= 1'b0;
                    if (r_underrun) begin
                        r_dir_chg <= w_dir_edge;
                        r_state   <= S_DRAIN;
                    end else if (w_dir_edge) begin
                        r_state <= S_TURN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (w_dir_edge) begin
                        r_dir_chg <= 1'b1;
                    end
                    if (pkt_valid_i && pkt_last_i) begin
                        r_dir_chg <= 1'b0;
                        r_state   <= (r_dir_chg || w_dir_edge) ? S_TURN : S_IDLE;
                    end
                end

                default: begin
                    r_tx_oe <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_tx_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ulpi_tx_sequencer
// Description : Scoreboard bench for ulpi_tx_sequencer. Directed packets are
//               fed from a byte source; expected bus events are queued by the
//               stimulus and popped by an independent negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpi_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_last;
    logic       pkt_ready;
    logic       dir;
    logic       nxt;
    logic       stp;
    logic       tx_oe;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       abort;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } src_t;

    src_t       src_q[$];
    logic [9:0] exp_q[$];   // {kind, data}: 0 byte taken, 1 stp, 2 done, 3 abort
    logic       src_flush = 1'b0;

    always #5 clk = ~clk;

    ulpi_tx_sequencer #(
        .TXCMD_CODE (2'b01),
        .IDLE_GAP   (2)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pkt_data_i  (pkt_data),
        .pkt_valid_i (pkt_valid),
        .pkt_last_i  (pkt_last),
        .pkt_ready_o (pkt_ready),
        .ulpi_dir_i  (dir),
        .ulpi_nxt_i  (nxt),
        .ulpi_stp_o  (stp),
        .tx_oe_o     (tx_oe),
        .tx_data_o   (tx_data),
        .busy_o      (busy),
        .tx_done_o   (done),
        .tx_abort_o  (abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic observe(input logic [9:0] ev);
        logic [9:0] want;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %02h, required nothing", ev[9:8], ev[7:0]);
        end else begin
            want = exp_q.pop_front();
            if (ev !== want) begin
                n_fail++;
                $display("FAIL bus_event: got kind %0d data %02h, required kind %0d data %02h",
                         ev[9:8], ev[7:0], want[9:8], want[7:0]);
            end
        end
    endtask

    task automatic src_push(input logic [7:0] d, input logic l, input int g);
        src_t e;
        e.data = d;
        e.last = l;
        e.gap  = g;
        src_q.push_back(e);
    endtask

    task automatic exp_byte(input logic [7:0] d); exp_q.push_back({2'd0, d}); endtask
    task automatic exp_stp(input logic [7:0] d);  exp_q.push_back({2'd1, d}); endtask
    task automatic exp_done();  exp_q.push_back({2'd2, 8'h00}); endtask
    task automatic exp_abort(); exp_q.push_back({2'd3, 8'h00}); endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_oe(input string name);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!tx_oe && k < 50);
        check(name, tx_oe, 1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (busy && k < 50);
        check(name, busy, 0);
    endtask

    // Byte source: presents the head of src_q, honours per-byte valid gaps
    initial begin : p_source
        logic take;
        pkt_valid = 1'b0;
        pkt_data  = 8'h00;
        pkt_last  = 1'b0;
        forever begin
            @(negedge clk);
            take = pkt_valid & pkt_ready;
            @(posedge clk);
            #1;
            if (src_flush) begin
                src_q.delete();
                pkt_valid = 1'b0;
            end else begin
                if (take && src_q.size() > 0) void'(src_q.pop_front());
                if (src_q.size() > 0 && src_q[0].gap > 0) begin
                    pkt_valid = 1'b0;
                    src_q[0].gap = src_q[0].gap - 1;
                end else if (src_q.size() > 0) begin
                    pkt_valid = 1'b1;
                    pkt_data  = src_q[0].data;
                    pkt_last  = src_q[0].last;
                end else begin
                    pkt_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: turns bus activity into events and checks them in order
    initial begin : p_monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pkt_ready) check("ready_without_valid", pkt_valid, 1);
                if (stp)                      observe({2'd1, tx_data});
                else if (tx_oe && nxt && !dir) observe({2'd0, tx_data});
                if (done)  observe({2'd2, 8'h00});
                if (abort) observe({2'd3, 8'h00});
            end
        end
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        rst_n = 1'b0;
        dir   = 1'b0;
        nxt   = 1'b0;
        repeat (3) cyc();
        check("reset_oe", tx_oe, 0);
        check("reset_data", tx_data, 0);
        check("reset_stp", stp, 0);
        check("reset_busy", busy, 0);
        check("reset_pulses", {done, abort}, 0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Three-byte packet, PHY accepts every cycle
        src_push(8'hC3, 1'b0, 0);
        src_push(8'h11, 1'b0, 0);
        src_push(8'h22, 1'b1, 0);
        exp_byte(8'h43); exp_byte(8'h11); exp_byte(8'h22); exp_stp(8'h00); exp_done();
        wait_oe("t1_txcmd_timeout");
        nxt = 1'b1;
        wait_idle("t1_idle_timeout");
        nxt = 1'b0;
        repeat (4) cyc();

        // PID-only packet, TX CMD held until nxt on its third cycle
        src_push(8'hD2, 1'b1, 0);
        exp_byte(8'h42); exp_stp(8'h00); exp_done();
        wait_oe("t2_txcmd_timeout");
        check("t2_hold_c1", tx_data, 8'h42);
        cyc();
        check("t2_hold_c2", tx_data, 8'h42);
        cyc();
        check("t2_hold_c3", tx_data, 8'h42);
        nxt = 1'b1;
        wait_idle("t2_idle_timeout");
        nxt = 1'b0;
        repeat (4) cyc();

        // PHY takes the bus while TX CMD waits; TX CMD must be retried
        src_push(8'hC3, 1'b0, 0);
        src_push(8'h55, 1'b1, 0);
        exp_byte(8'h43); exp_byte(8'h55); exp_stp(8'h00); exp_done();
        wait_oe("t3_txcmd_timeout");
        dir = 1'b1;
        cyc();
        check("t3_oe_drop", tx_oe, 0);
        repeat (3) cyc();
        dir = 1'b0;
        wait_oe("t3_retry_timeout");
        check("t3_retry_cmd", tx_data, 8'h43);
        nxt = 1'b1;
        wait_idle("t3_idle_timeout");
        nxt = 1'b0;
        repeat (4) cyc();

        // Bus lost mid-DATA: abort, rest of the packet drained, next packet clean
        src_push(8'hA5, 1'b0, 0);
        src_push(8'h33, 1'b0, 0);
        src_push(8'h44, 1'b0, 0);
        src_push(8'h66, 1'b1, 0);
        exp_byte(8'h45); exp_byte(8'h33); exp_abort();
        wait_oe("t4_txcmd_timeout");
        nxt = 1'b1;
        cyc();
        cyc();
        dir = 1'b1;
        nxt = 1'b0;
        repeat (4) cyc();
        check("t4_oe_low", tx_oe, 0);
        check("t4_drained", src_q.size(), 0);
        dir = 1'b0;
        wait_idle("t4_idle_timeout");
        repeat (3) cyc();
        src_push(8'hC3, 1'b0, 0);
        src_push(8'h77, 1'b1, 0);
        exp_byte(8'h43); exp_byte(8'h77); exp_stp(8'h00); exp_done();
        wait_oe("t4b_txcmd_timeout");
        nxt = 1'b1;
        wait_idle("t4b_idle_timeout");
        nxt = 1'b0;
        repeat (4) cyc();

        // Underrun after D0: FF with STP, abort, drain to the last byte
        src_push(8'hB4, 1'b0, 0);
        src_push(8'h12, 1'b0, 0);
        src_push(8'h34, 1'b0, 3);
        src_push(8'h56, 1'b1, 0);
        exp_byte(8'h44); exp_byte(8'h12); exp_stp(8'hFF); exp_abort();
        wait_oe("t5_txcmd_timeout");
        nxt = 1'b1;
        wait_idle("t5_idle_timeout");
        nxt = 1'b0;
        cyc();
        check("t5_drained", src_q.size(), 0);
        repeat (4) cyc();

        // Asynchronous reset in the middle of DATA
        src_push(8'hC3, 1'b0, 0);
        src_push(8'h11, 1'b0, 0);
        src_push(8'h22, 1'b0, 0);
        src_push(8'h33, 1'b1, 0);
        exp_byte(8'h43);
        wait_oe("t6_txcmd_timeout");
        nxt = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_oe", tx_oe, 0);
        check("t6_async_data", tx_data, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_stp", stp, 0);
        nxt       = 1'b0;
        src_flush = 1'b1;
        repeat (3) cyc();
        src_flush = 1'b0;
        rst_n     = 1'b1;
        repeat (2) cyc();
        src_push(8'hE1, 1'b0, 0);
        src_push(8'h99, 1'b1, 0);
        exp_byte(8'h41); exp_byte(8'h99); exp_stp(8'h00); exp_done();
        wait_oe("t6b_txcmd_timeout");
        nxt = 1'b1;
        wait_idle("t6b_idle_timeout");
        nxt = 1'b0;
        repeat (5) cyc();

        check("events_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
